// File: rtl/wb_host_master_if.sv
// Bundle of the command/response handshakes and Wishbone initiator signals of wb_host_master.
// The master modport is the host side; the slave modport is the view from whatever drives it.
interface wb_host_master_if #(
  parameter int TO_CNT_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [3:0]          cmd_sel;
  logic [31:0]         cmd_adr;
  logic [31:0]         cmd_dat;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_dat;
  logic                rsp_err;
  logic                wbm_cyc_o;
  logic                wbm_stb_o;
  logic                wbm_we_o;
  logic [3:0]          wbm_sel_o;
  logic [31:0]         wbm_adr_o;
  logic [31:0]         wbm_dat_o;
  logic [31:0]         wbm_dat_i;
  logic                wbm_ack_i;
  logic                wbm_err_i;
  logic                busy;
  logic [TO_CNT_W-1:0] to_count;

  modport master (
    input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output busy, to_count
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  busy, to_count
  );
endinterface

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus cycle, one response out.
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// BUS   | CYC/STB asserted, waiting for ACK/ERR or timeout
// RSP   | response held on rsp_* until consumed
module wb_host_master #(
  parameter int TIMEOUT  = 16,
  parameter int TO_CNT_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  wb_host_master_if.master   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [31:0]         rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    timer_d   = timer_q;
    to_cnt_d  = to_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr & 32'hFFFF_FFFC;
          dat_d   = bus.cmd_dat;
          cyc_d   = 1'b1;
          timer_d = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // ERR beats ACK, and either beats a timeout expiring on the same edge
        if (bus.wbm_err_i) begin
          cyc_d     = 1'b0;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          state_d   = S_RSP;
        end else if (bus.wbm_ack_i) begin
          cyc_d     = 1'b0;
          rsp_err_d = 1'b0;
          rsp_dat_d = we_q ? 32'h0 : bus.wbm_dat_i;
          state_d   = S_RSP;
        end else if ((TIMEOUT != 0) && (timer_q == TMAX)) begin
          cyc_d     = 1'b0;
          rsp_err_d = 1'b1;
          rsp_dat_d = '0;
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_CNT_W'(1);
          state_d   = S_RSP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      timer_q   <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      timer_q   <= timer_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.to_count  = to_cnt_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized scoreboard bench for wb_host_master with a scripted Wishbone slave and response consumer.
module tb_wb_host_master;
  localparam int T = 4;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_NONE = 3;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    logic [7:0]  to;
    int          rd;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          w;
    int          kind;
    int          stb;
  } slv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_host_master_if #(.TO_CNT_W(8)) bus ();
  wb_host_master #(.TIMEOUT(T), .TO_CNT_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus)
  );

  int   checks = 0;
  int   errors = 0;
  bit   stray_en = 1'b0;
  logic [7:0] model_to = 8'h00;
  exp_t exp_q[$];
  slv_t slv_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response consumer and checker: compares every valid cycle, consumes after rd cycles.
  int vcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.rsp_ready = 1'b0;
      vcnt = 0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=valid expected=none at %0t", $time);
        bus.rsp_ready = 1'b1;
      end else begin
        exp_t e;
        e = exp_q[0];
        chk("rsp_err", bus.rsp_err, e.err);
        chk("rsp_dat", bus.rsp_dat, e.dat);
        chk("to_count", bus.to_count, e.to);
        chk("rsp_hold", {bus.cmd_ready, bus.busy, bus.wbm_cyc_o}, 3'b010);
        vcnt++;
        if (vcnt > e.rd) begin
          bus.rsp_ready = 1'b1;
          void'(exp_q.pop_front());
          vcnt = 0;
        end else begin
          bus.rsp_ready = 1'b0;
        end
      end
    end else begin
      bus.rsp_ready = 1'b0;
      vcnt = 0;
    end
  end

  // Scripted slave: responds on STB cycle w+1, checks bus fields and STB length.
  bit   active = 1'b0;
  bit   have = 1'b0;
  int   scnt = 0;
  slv_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
    end else if (bus.wbm_cyc_o) begin
      if (!active) begin
        active = 1'b1;
        scnt = 0;
        have = (slv_q.size() != 0);
        if (have) cur = slv_q.pop_front();
      end
      scnt++;
      if (have) begin
        chk("bus_ctl", {bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o},
            {1'b1, cur.we, cur.sel, cur.adr});
        chk("bus_wdat", bus.wbm_dat_o, cur.dat);
      end
      if (have && cur.kind != K_NONE && scnt == cur.w + 1) begin
        bus.wbm_ack_i = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
        bus.wbm_err_i = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
        bus.wbm_dat_i = cur.rdata;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = $urandom;
      end
    end else begin
      if (active && have) chk("stb_cycles", scnt, cur.stb);
      active = 1'b0;
      bus.wbm_ack_i = stray_en;
      bus.wbm_err_i = stray_en;
      bus.wbm_dat_i = $urandom;
    end
  end

  task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [31:0] rdata,
                       input int w, input int kind, input int rd, input bit track);
    int   n;
    exp_t e;
    slv_t s;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_sel   = sel;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1'b1);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (track) begin
      s.we = we; s.sel = sel; s.adr = adr & 32'hFFFF_FFFC; s.dat = dat;
      s.rdata = rdata; s.w = w; s.kind = kind;
      s.stb = (kind == K_NONE) ? T : ((w + 1 < T) ? w + 1 : T);
      if (kind == K_NONE || w >= T) begin
        e.err = 1'b1;
        e.dat = 32'h0;
        if (model_to != 8'hFF) model_to = model_to + 8'd1;
      end else if (kind != K_ACK) begin
        e.err = 1'b1;
        e.dat = 32'h0;
      end else begin
        e.err = 1'b0;
        e.dat = we ? 32'h0 : rdata;
      end
      e.to = model_to;
      e.rd = rd;
      slv_q.push_back(s);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("cyc_after_accept", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.cmd_ready}, 3'b110);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {exp_q.size() == 0, bus.busy}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'h0;
    bus.cmd_adr   = 32'h0;
    bus.cmd_dat   = 32'h0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outs", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.busy, bus.rsp_valid, bus.cmd_ready},
        6'b000001);
    chk("reset_regs", {bus.rsp_dat, bus.rsp_err, bus.to_count, bus.wbm_adr_o}, 73'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 0, K_ACK, 0, 1'b1);
    issue(1'b0, 4'h3, 32'h3000_0010, 32'h0, 32'h1234_5678, 3, K_ACK, 5, 1'b1);
    issue(1'b0, 4'hF, 32'h3000_0020, 32'h0, 32'hCAFE_F00D, 0, K_BOTH, 0, 1'b1);
    issue(1'b0, 4'h5, 32'h1000_0007, 32'h5555_AAAA, 32'h0BAD_CAFE, 1, K_ACK, 1, 1'b1);
    issue(1'b1, 4'hC, 32'h1000_0002, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 2, K_ERR, 0, 1'b1);
    wait_idle();

    for (int i = 0; i < 300; i++)
      issue(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom, 0, K_NONE, 0, 1'b1);
    wait_idle();
    chk("to_saturated", bus.to_count, 8'hFF);

    for (int i = 0; i < 200; i++) begin
      int k, kind;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      k = $urandom_range(0, 9);
      kind = (k <= 5) ? K_ACK : (k == 6) ? K_ERR : (k == 7) ? K_BOTH : K_NONE;
      issue(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 5), kind, $urandom_range(0, 3), 1'b1);
    end
    wait_idle();

    // Reset during a wait state must abort the cycle with no response.
    issue(1'b0, 4'hF, 32'h2000_0000, 32'h0, 32'h0, 0, K_NONE, 0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_abort", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.busy, bus.rsp_valid}, 4'b0000);
    model_to = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", {bus.cmd_ready, bus.busy, bus.to_count}, {1'b1, 1'b0, 8'h00});
    stray_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_ignored", {bus.busy, bus.rsp_valid, bus.wbm_cyc_o, bus.to_count}, 11'h0);
    end
    stray_en = 1'b0;
    issue(1'b0, 4'hA, 32'h3000_0044, 32'h0, 32'h8765_4321, 1, K_ACK, 0, 1'b1);
    issue(1'b1, 4'hF, 32'h3000_0048, 32'h1111_2222, 32'h0, 5, K_ACK, 0, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Single-outstanding Wishbone classic (B3, non-pipelined) initiator.
- Converts a valid/ready command port into one Wishbone read or write cycle. Returns read data and error status on a valid/ready response port.
- Sits in the user area opposite our Wishbone slave blocks. Used to drive a slave, such as the counter block, from local logic (LA-driven sequencer or test harness) rather than from the management SoC.
- Includes a bus timeout and a saturating timeout statistic.

Parameters:
- TIMEOUT, 16, max cycles STB is held awaiting ACK/ERR; 0 disables the timeout.
- TO_CNT_W, 8, width of the saturating timeout statistic counter.

Ports:
- wb_clk_i  input  1  sole clock; all logic on rising edge.
- wb_rst_n_i  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_we  input  1  1=write, 0=read.
- cmd_sel  input  4  byte selects.
- cmd_adr  input  32  byte address.
- cmd_dat  input  32  write data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_dat  output  32  read data; 0 for writes and for errors.
- rsp_err  output  1  1 = bus ERR or timeout.
- wbm_cyc_o  output  1  Wishbone CYC.
- wbm_stb_o  output  1  Wishbone STB.
- wbm_we_o  output  1  Wishbone WE.
- wbm_sel_o  output  4  Wishbone SEL.
- wbm_adr_o  output  32  Wishbone address, bits [1:0] forced 0.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone ACK.
- wbm_err_i  input  1  Wishbone ERR.
- busy  output  1  high in any state other than IDLE.
- to_count  output  TO_CNT_W  number of timeouts, saturating at all-ones.

Behaviour:
- Reset (async assert, sync use after deassert): state=IDLE. All outputs 0 except cmd_ready=1 once in IDLE. Register values: rsp_dat=0, rsp_err=0, to_count=0, timer=0. Reset mid-cycle drops CYC/STB immediately; no response is produced for the aborted command.
- All Wishbone outputs and rsp_* are registered; there are no combinational paths from inputs to outputs except cmd_ready = (state==IDLE).
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept: latch we/sel/adr/dat into the wbm_* registers, assert cyc=stb=1, clear the timer, go to BUS.
  - Cycle N is the accept edge; CYC/STB are high from cycle N+1.
- BUS:
  - cyc/stb/we/sel/adr/dat are held stable; cmd_ready=0.
  - Sampled wbm_err_i=1: cyc=stb=0, rsp_err=1, rsp_dat=0, go to RSP. ERR has priority if ACK and ERR are both high.
  - Else sampled wbm_ack_i=1: cyc=stb=0, rsp_err=0, rsp_dat = we ? 0 : wbm_dat_i, go to RSP.
  - Else, if TIMEOUT!=0 and timer==TIMEOUT-1: abort with cyc=stb=0, rsp_err=1, rsp_dat=0, to_count+=1 (saturating), go to RSP.
  - Else timer+=1.
  - An ACK on the same edge as the timeout expiry counts as success, not timeout.
  - Latency: ACK sampled at edge k gives CYC low and rsp_valid=1 in cycle k+1. Minimum command-accept to rsp_valid is 2 cycles.
  - With TIMEOUT=T, STB stays high for exactly T cycles before the abort.
- RSP:
  - rsp_valid=1; rsp_dat and rsp_err stay stable until consumed.
  - On rsp_valid && rsp_ready: rsp_valid=0, go to IDLE. The next command can be accepted one cycle later.
  - rsp_ready held high gives one transaction per 3 cycles minimum against a zero-wait slave.
- wbm_ack_i/wbm_err_i seen in IDLE or RSP (stray) are ignored; state and to_count are unchanged.
- wbm_dat_i is sampled only on the ACK edge in BUS.
- Timer width is clog2(TIMEOUT)+1; when TIMEOUT=0 it never expires and a hung slave holds BUS indefinitely.
- cmd_sel is passed unmodified for both reads and writes; cmd_adr[1:0] is discarded.

Test Plan:
- Write, zero-wait slave: cmd adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF, we=1. Expect CYC/STB high 1 cycle after accept, wbm_adr_o=0x3000_0004, wbm_dat_o=0xDEADBEEF, wbm_we_o=1. ACK the next cycle; rsp_valid with rsp_err=0, rsp_dat=0.
- Read with 3 wait states: slave returns 0x1234_5678 on ACK 3 cycles after STB. Expect STB held 4 cycles with stable address, then rsp_dat=0x12345678, rsp_err=0. rsp_ready held low 5 cycles: rsp_valid and rsp_dat stay stable and cmd_ready stays 0.
- ERR and ACK together: slave asserts both in the first STB cycle. Expect rsp_err=1, rsp_dat=0, to_count unchanged.
- Timeout, TIMEOUT=4, slave never responds. Expect STB high exactly 4 cycles, then CYC low, rsp_err=1, to_count=1. Repeat 300 times with TO_CNT_W=8: to_count saturates at 255.
- ACK on the expiry cycle (TIMEOUT=4, ACK in the 4th STB cycle): expect success, rsp_err=0, to_count unchanged.
- Reset mid-BUS: assert wb_rst_n_i low during a wait state. Expect CYC/STB/busy 0 asynchronously (before next edge), no rsp_valid afterwards, cmd_ready=1 on the first edge after release. A stray ACK in IDLE is ignored.
